// File: rtl/memory_copier_if.sv
// Command and cpu_memory bus bundle for memory_copier.
// MEMORY_COPIER_FILL_EN adds the cmd_fill / cmd_fill_value command fields.
interface memory_copier_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
);
    // Command: accepted on a rising edge where cmd_valid && cmd_ready; the
    // offerer holds the fields stable until then. Memory: mem_start is a
    // one-cycle request, and mem_ready high means the access has finished.
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_src;
    logic [ADDR_WIDTH-1:0] cmd_dst;
    logic [LEN_WIDTH-1:0]  cmd_len;
`ifdef MEMORY_COPIER_FILL_EN
    logic                  cmd_fill;
    logic [7:0]            cmd_fill_value;
`endif
    logic                  busy;
    logic                  done;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [7:0]            mem_data_in;
    logic                  mem_direction;
    logic                  mem_start;
    logic [7:0]            mem_data_out;
    logic                  mem_ready;

`ifdef MEMORY_COPIER_FILL_EN
    modport master (
        input  cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_fill, cmd_fill_value,
        output cmd_ready, busy, done,
        output mem_address, mem_data_in, mem_direction, mem_start,
        input  mem_data_out, mem_ready
    );

    modport slave (
        output cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_fill, cmd_fill_value,
        input  cmd_ready, busy, done,
        input  mem_address, mem_data_in, mem_direction, mem_start,
        output mem_data_out, mem_ready
    );
`else
    modport master (
        input  cmd_valid, cmd_src, cmd_dst, cmd_len,
        output cmd_ready, busy, done,
        output mem_address, mem_data_in, mem_direction, mem_start,
        input  mem_data_out, mem_ready
    );

    modport slave (
        output cmd_valid, cmd_src, cmd_dst, cmd_len,
        input  cmd_ready, busy, done,
        input  mem_address, mem_data_in, mem_direction, mem_start,
        output mem_data_out, mem_ready
    );
`endif
endinterface

// File: rtl/memory_copier.sv
// Block-copy engine: byte-wise read/write loop over the cpu_memory port.
// Define MEMORY_COPIER_FILL_EN to add a fill mode that writes a constant.
module memory_copier #(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic               clock,
    input  logic               reset,
    memory_copier_if.master    bus,
    output logic [2:0]         debug_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_START = 3'd1,
        RD_WAIT  = 3'd2,
        WR_START = 3'd3,
        WR_WAIT  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            byte_q;
    logic                  dir_q;

    logic                  accept;
    logic                  cmd_empty;
    logic                  last_byte;
    logic                  fill_cmd;
    logic                  fill_q;
    logic [7:0]            fill_value;
    logic [ADDR_WIDTH-1:0] src_inc;
    logic [ADDR_WIDTH-1:0] dst_inc;

`ifdef MEMORY_COPIER_FILL_EN
    assign fill_cmd   = bus.cmd_fill;
    assign fill_value = bus.cmd_fill_value;

    always_ff @(posedge clock) begin
        if (reset) begin
            fill_q <= 1'b0;
        end else if (accept) begin
            fill_q <= bus.cmd_fill;
        end
    end
`else
    assign fill_cmd   = 1'b0;
    assign fill_value = 8'h00;
    assign fill_q     = 1'b0;
`endif

    assign accept    = bus.cmd_valid && (state == IDLE);
    assign cmd_empty = (bus.cmd_len == '0);
    assign last_byte = (len_q == LEN_WIDTH'(1));
    // Address arithmetic wraps silently modulo 2^ADDR_WIDTH.
    assign src_inc   = src_q + ADDR_WIDTH'(1);
    assign dst_inc   = dst_q + ADDR_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_empty) begin
                        state_nxt = DONE;
                    end else if (fill_cmd) begin
                        state_nxt = WR_START;
                    end else begin
                        state_nxt = RD_START;
                    end
                end
            end
            RD_START: state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (bus.mem_ready) begin
                    state_nxt = WR_START;
                end
            end
            WR_START: state_nxt = WR_WAIT;
            WR_WAIT: begin
                if (bus.mem_ready) begin
                    if (last_byte) begin
                        state_nxt = DONE;
                    end else if (fill_q) begin
                        state_nxt = WR_START;
                    end else begin
                        state_nxt = RD_START;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Address/data/direction are loaded one cycle ahead of the START state
    // that uses them, so the bus outputs come straight from flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            addr_q <= '0;
            byte_q <= 8'h00;
            dir_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        src_q <= bus.cmd_src;
                        dst_q <= bus.cmd_dst;
                        len_q <= bus.cmd_len;
                        if (!cmd_empty) begin
                            if (fill_cmd) begin
                                addr_q <= bus.cmd_dst;
                                byte_q <= fill_value;
                                dir_q  <= 1'b1;
                            end else begin
                                addr_q <= bus.cmd_src;
                                dir_q  <= 1'b0;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    if (bus.mem_ready) begin
                        byte_q <= bus.mem_data_out;
                        addr_q <= dst_q;
                        dir_q  <= 1'b1;
                    end
                end
                WR_WAIT: begin
                    if (bus.mem_ready) begin
                        src_q <= src_inc;
                        dst_q <= dst_inc;
                        len_q <= len_q - LEN_WIDTH'(1);
                        if (!last_byte) begin
                            if (fill_q) begin
                                addr_q <= dst_inc;
                            end else begin
                                addr_q <= src_inc;
                                dir_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready     = (state == IDLE);
    assign bus.busy          = (state != IDLE);
    assign bus.done          = (state == DONE);
    assign bus.mem_start     = (state == RD_START) || (state == WR_START);
    assign bus.mem_address   = addr_q;
    assign bus.mem_data_in   = byte_q;
    assign bus.mem_direction = dir_q;
    assign debug_state       = state;

endmodule

// File: tb/tb_memory_copier.sv
// Directed bench for memory_copier: behavioural memory, access scoreboard,
// and content checks after each command.
module tb_memory_copier;
  localparam int AW = 16;
  localparam int LW = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  memory_copier_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();
  logic [2:0] debug_state;

  memory_copier #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .debug_state(debug_state)
  );

  // ---------------- memory model ----------------
  logic [7:0]  mem [0:65535];
  int          rd_lat;
  int          wr_lat;
  int          lat_cnt;
  logic        pend_dir;
  logic [15:0] pend_addr;
  logic [7:0]  pend_data;
  int          wr_done_cnt;
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (reset) begin
      bus.mem_ready    <= 1'b1;
      bus.mem_data_out <= 8'h00;
      lat_cnt          <= 0;
      wr_done_cnt      <= 0;
    end else if (bus.mem_start) begin
      bus.mem_ready <= 1'b0;
      pend_dir      <= bus.mem_direction;
      pend_addr     <= bus.mem_address;
      pend_data     <= bus.mem_data_in;
      lat_cnt       <= bus.mem_direction ? wr_lat : rd_lat;
    end else if (!bus.mem_ready) begin
      if (lat_cnt == 0) begin
        if (pend_dir) begin
          mem[pend_addr] <= pend_data;
          wr_done_cnt    <= wr_done_cnt + 1;
        end else begin
          bus.mem_data_out <= mem[pend_addr];
        end
        bus.mem_ready <= 1'b1;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  logic [24:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_rd(input logic [15:0] addr);
    exp_q.push_back({1'b0, addr, 8'h00});
  endtask

  task automatic push_wr(input logic [15:0] addr, input logic [7:0] data);
    exp_q.push_back({1'b1, addr, data});
  endtask

  // Monitor: every mem_start pulse is popped against the expected queue.
  initial begin
    logic prev_start;
    logic [24:0] got;
    logic [24:0] e;
    prev_start = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_start = 1'b0;
      end else begin
        if (bus.mem_start) begin
          start_cnt++;
          if (!bus.mem_direction) rd_cnt++;
          check("start_gap", 32'(prev_start), 0);
          got = {bus.mem_direction, bus.mem_address,
                 bus.mem_direction ? bus.mem_data_in : 8'h00};
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_access: got 0x%0h expected none", got);
          end else begin
            e = exp_q.pop_front();
            check("mem_access", 32'(got), 32'(e));
          end
        end
        if (bus.done) done_cnt++;
        prev_start = bus.mem_start;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clock);
    pre_addr = addr;
    pre_data = data;
    pre_we   = 1'b1;
    @(negedge clock);
    pre_we   = 1'b0;
  endtask

  task automatic offer(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    int n;
    @(negedge clock);
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("cmd_ready_timeout", 32'(n), 0);
    @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [15:0] src, input logic [15:0] dst,
                         input logic [15:0] len, input int exp_starts);
    int base_start;
    int base_done;
    int n;
    base_start = start_cnt;
    base_done  = done_cnt;
    offer(src, dst, len);
    if (len == 16'h0) begin
      check("zero_len_done_latency", 32'(bus.done), 1);
      check("zero_len_busy", 32'(bus.busy), 1);
    end else begin
      check("first_start_latency", 32'(bus.mem_start), 1);
    end
    n = 0;
    while (done_cnt == base_done && n < 2000) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (n >= 2000) check("done_timeout", 32'(n), 0);
    repeat (3) @(negedge clock);
    #1;
    check("done_pulses", 32'(done_cnt - base_done), 1);
    check("start_pulses", 32'(start_cnt - base_start), 32'(exp_starts));
    check("exp_q_drained", 32'(exp_q.size()), 0);
    check("idle_after_done", 32'(bus.cmd_ready), 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int n;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    bus.cmd_len   = '0;
`ifdef MEMORY_COPIER_FILL_EN
    bus.cmd_fill       = 1'b0;
    bus.cmd_fill_value = 8'h00;
`endif
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    rd_lat   = 0;
    wr_lat   = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_mem_start", 32'(bus.mem_start), 0);
    check("rst_mem_direction", 32'(bus.mem_direction), 0);
    check("rst_mem_address", 32'(bus.mem_address), 0);
    check("rst_mem_data_in", 32'(bus.mem_data_in), 0);
    check("rst_state", 32'(debug_state), 0);
    reset = 1'b0;

    // Basic copy, zero-latency memory.
    poke(16'h0010, 8'hA1);
    poke(16'h0011, 8'hB2);
    poke(16'h0012, 8'hC3);
    poke(16'h0013, 8'hD4);
    push_rd(16'h0010); push_wr(16'h0080, 8'hA1);
    push_rd(16'h0011); push_wr(16'h0081, 8'hB2);
    push_rd(16'h0012); push_wr(16'h0082, 8'hC3);
    push_rd(16'h0013); push_wr(16'h0083, 8'hD4);
    run_cmd(16'h0010, 16'h0080, 16'd4, 8);
    check("basic_mem_80", 32'(mem[16'h0080]), 32'h A1);
    check("basic_mem_81", 32'(mem[16'h0081]), 32'h B2);
    check("basic_mem_82", 32'(mem[16'h0082]), 32'h C3);
    check("basic_mem_83", 32'(mem[16'h0083]), 32'h D4);

    // Zero length: done one cycle after acceptance, no accesses.
    run_cmd(16'h1234, 16'h5678, 16'd0, 0);

    // Address wrap-around with non-zero latencies.
    rd_lat = 2;
    wr_lat = 1;
    poke(16'hFFFE, 8'h10);
    poke(16'hFFFF, 8'h20);
    poke(16'h0000, 8'h30);
    poke(16'h0001, 8'h40);
    push_rd(16'hFFFE); push_wr(16'h7FFE, 8'h10);
    push_rd(16'hFFFF); push_wr(16'h7FFF, 8'h20);
    push_rd(16'h0000); push_wr(16'h8000, 8'h30);
    push_rd(16'h0001); push_wr(16'h8001, 8'h40);
    run_cmd(16'hFFFE, 16'h7FFE, 16'd4, 8);
    check("wrap_mem_7ffe", 32'(mem[16'h7FFE]), 32'h10);
    check("wrap_mem_8001", 32'(mem[16'h8001]), 32'h40);

    // Overlapping regions replicate the first source byte.
    rd_lat = 1;
    wr_lat = 3;
    poke(16'h0020, 8'h55);
    poke(16'h0021, 8'h11);
    poke(16'h0022, 8'h22);
    poke(16'h0023, 8'h33);
    push_rd(16'h0020); push_wr(16'h0021, 8'h55);
    push_rd(16'h0021); push_wr(16'h0022, 8'h55);
    push_rd(16'h0022); push_wr(16'h0023, 8'h55);
    run_cmd(16'h0020, 16'h0021, 16'd3, 6);
    check("overlap_mem_21", 32'(mem[16'h0021]), 32'h55);
    check("overlap_mem_22", 32'(mem[16'h0022]), 32'h55);
    check("overlap_mem_23", 32'(mem[16'h0023]), 32'h55);

    // Reset mid-copy after three bytes have been written.
    rd_lat = 1;
    wr_lat = 1;
    for (int i = 0; i < 8; i++) begin
      poke(16'h0100 + 16'(i), 8'h60 + 8'(i));
      poke(16'h0200 + 16'(i), 8'hEE);
    end
    for (int i = 0; i < 8; i++) begin
      push_rd(16'h0100 + 16'(i));
      push_wr(16'h0200 + 16'(i), 8'h60 + 8'(i));
    end
    @(negedge clock);
    base = wr_done_cnt;
    offer(16'h0100, 16'h0200, 16'd8);
    n = 0;
    while (wr_done_cnt != base + 3 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 1000) check("reset_mid_wait_timeout", 32'(n), 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_mem_start", 32'(bus.mem_start), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 1);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    repeat (4) @(negedge clock);
    check("abort_mem_200", 32'(mem[16'h0200]), 32'h60);
    check("abort_mem_202", 32'(mem[16'h0202]), 32'h62);
    check("abort_mem_203", 32'(mem[16'h0203]), 32'hEE);
    check("abort_mem_207", 32'(mem[16'h0207]), 32'hEE);

`ifdef MEMORY_COPIER_FILL_EN
    // Fill mode: writes only, constant value.
    rd_lat = 0;
    wr_lat = 2;
    for (int i = 0; i < 5; i++) poke(16'h0300 + 16'(i), 8'hFF);
    for (int i = 0; i < 5; i++) push_wr(16'h0300 + 16'(i), 8'h00);
    base = rd_cnt;
    bus.cmd_fill       = 1'b1;
    bus.cmd_fill_value = 8'h00;
    run_cmd(16'h0040, 16'h0300, 16'd5, 5);
    bus.cmd_fill       = 1'b0;
    check("fill_reads", 32'(rd_cnt - base), 0);
    for (int i = 0; i < 5; i++) check("fill_mem", 32'(mem[16'h0300 + 16'(i)]), 0);
`endif

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/memory_copier.md
# memory_copier

Block-copy engine that acts as the initiator on the `cpu_memory` request interface. It accepts one copy command at a time (source, destination, length), then issues alternating single-byte reads and writes through the `start`/`ready` handshake until the length is exhausted. It sits beside the CPU core and shares the `cpu_memory` port with it through an external arbiter. Typical uses are sprite/font staging and clearing RAM regions.

## Interface
- `ADDR_WIDTH`, default 16: memory address width; matches `cpu_memory` address.
- `LEN_WIDTH`, default 16: byte-count width.
- `clock`, in, 1: sole clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: engine can accept a command (high only in IDLE).
- `cmd_src`, in, ADDR_WIDTH: first source address.
- `cmd_dst`, in, ADDR_WIDTH: first destination address.
- `cmd_len`, in, LEN_WIDTH: byte count; 0 is legal.
- `busy`, out, 1: high from the cycle after acceptance until `done`.
- `done`, out, 1: one-cycle pulse when the command completes.
- `mem_address`, out, ADDR_WIDTH: to `cpu_memory` address.
- `mem_data_in`, out, 8: write data to `cpu_memory` `data_in`.
- `mem_direction`, out, 1: 1 = write, 0 = read.
- `mem_start`, out, 1: one-cycle request pulse.
- `mem_data_out`, in, 8: read data from `cpu_memory` `data_out`.
- `mem_ready`, in, 1: memory idle / previous access complete.

## Operation
- States: IDLE, RD_START, RD_WAIT, WR_START, WR_WAIT, DONE.
- IDLE: `cmd_ready`=1. A command is accepted when `cmd_valid && cmd_ready`; src, dst and len are latched.
  - If len==0, go to DONE with no memory access.
  - Otherwise go to RD_START.
- RD_START: drive `mem_address`=src, `mem_direction`=0, `mem_start`=1 for exactly this cycle. Go to RD_WAIT.
- RD_WAIT: `mem_start`=0; address and direction are held. On `mem_ready`=1, capture `mem_data_out` into the byte register and go to WR_START.
- WR_START: drive `mem_address`=dst, `mem_data_in`=byte, `mem_direction`=1, `mem_start`=1 for one cycle. Go to WR_WAIT.
- WR_WAIT: hold address, data and direction. On `mem_ready`=1:
  - src+=1, dst+=1, len-=1.
  - If the new len==0, go to DONE; else go to RD_START.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: 0xFFFF+1 → 0x0000, with no error flag.
- Copy direction is always ascending. Overlapping regions with dst>src replicate source bytes; this is defined behaviour, not an error.
- `cmd_valid` is ignored while not in IDLE. A command held valid across DONE is accepted in the following IDLE cycle.
- `reset` mid-operation aborts immediately: no further `mem_start`, and any in-flight access is abandoned. The arbiter is responsible for memory-side recovery.

## Timing
- Reset values:
  - `cmd_ready`=1
  - `busy`=0, `done`=0
  - `mem_start`=0, `mem_direction`=0
  - `mem_address`=0, `mem_data_in`=0
  - state IDLE
- All outputs are registered. `mem_start` is never high on two consecutive cycles.
- Memory contract: `mem_ready` is low in the cycle after any `mem_start` pulse. The engine therefore samples `mem_ready` only from the first RD_WAIT/WR_WAIT cycle onward.
- Per byte, with read latency Lr and write latency Lw (cycles of WAIT until `mem_ready`): 2 + Lr + Lw cycles.
- Command latency:
  - len==0: acceptance → `done` in 1 cycle.
  - Otherwise: first `mem_start` 1 cycle after acceptance; `done` 1 cycle after the last WR_WAIT completes.
- `busy` = state ≠ IDLE.

## Configuration
- `MEMORY_COPIER_FILL_EN` defined: adds inputs `cmd_fill` (1) and `cmd_fill_value` (8), both latched at acceptance. When `cmd_fill`=1:
  - RD_START/RD_WAIT are skipped (IDLE → WR_START).
  - Every write uses `cmd_fill_value`; src is ignored.
  - Per-byte cost is 1 + Lw.
- Undefined: the ports do not exist and only copy mode is implemented.

## Test plan
- Reset mid-copy: src=0x0100, dst=0x0200, len=8, `reset` after 3 bytes → next cycle `mem_start`=0, `busy`=0, `cmd_ready`=1; only 3 bytes written.
- Basic copy: preload 0x0010..0x0013 = 0xA1,0xB2,0xC3,0xD4; src=0x0010, dst=0x0080, len=4 → 0x0080..0x0083 match, exactly 8 `mem_start` pulses, one `done` pulse.
- Zero length: len=0 → `done` 1 cycle after acceptance, zero `mem_start` pulses.
- Wrap-around: src=0xFFFE, dst=0x7FFE, len=4 → reads 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order.
- Overlap: 0x0020=0x55, src=0x0020, dst=0x0021, len=3 → 0x0021..0x0023 all 0x55.
- Fill (with `MEMORY_COPIER_FILL_EN`): dst=0x0300, len=5, value=0x00 → 5 write pulses, no reads, 0x0300..0x0304 = 0x00.
